// File: rtl/control_sequencer_if.sv
// Opcode package and control bus shared by the sequencer and the ALU.
package control_seq_pkg;
  typedef enum logic [4:0] {
    OP_NOP  = 5'h00,
    OP_ADD  = 5'h01,
    OP_SUB  = 5'h02,
    OP_AND  = 5'h03,
    OP_OR   = 5'h04,
    OP_XOR  = 5'h05,
    OP_NOT  = 5'h06,
    OP_SHL  = 5'h07,
    OP_SHR  = 5'h08,
    OP_HALT = 5'h1F
  } opcode_e;
endpackage

interface control_bus_if #(
  parameter int OPCODE_W = 5
);
  logic [OPCODE_W-1:0] OPCODE;
  modport ctrl (output OPCODE);
  modport alu  (input  OPCODE);
endinterface

// File: rtl/control_sequencer.sv
// Fetch/decode/execute/writeback sequencer driving control_bus_if.
// CONTROL_SEQ_ILLEGAL_TRAP_EN: undefined opcodes set sticky illegal and halt.
module control_sequencer
  import control_seq_pkg::*;
#(
  parameter int WORD_SIZE  = 19,
  parameter int OPCODE_W   = 5,
  parameter int REG_ADDR_W = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  instr_req,
  output logic [WORD_SIZE-1:0]  instr_addr,
  input  logic                  instr_valid,
  input  logic [WORD_SIZE-1:0]  instr_data,
  control_bus_if.ctrl           ctrl_bus,
  output logic [REG_ADDR_W-1:0] rs1_addr,
  output logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  alu_en,
  output logic                  reg_we,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal
);

  localparam int OP_LSB  = WORD_SIZE - OPCODE_W;
  localparam int RD_LSB  = OP_LSB - REG_ADDR_W;
  localparam int RS1_LSB = RD_LSB - REG_ADDR_W;
  localparam int RS2_LSB = RS1_LSB - REG_ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] ir_q, ir_d;
  logic [OPCODE_W-1:0]  opc;
  logic                 op_wr;
  logic                 unused_ir;

  // IR loads on accept, so fields hold from DECODE to the next accept
  assign opc       = ir_q[OP_LSB +: OPCODE_W];
  assign rd_addr   = ir_q[RD_LSB +: REG_ADDR_W];
  assign rs1_addr  = ir_q[RS1_LSB +: REG_ADDR_W];
  assign rs2_addr  = ir_q[RS2_LSB +: REG_ADDR_W];
  assign unused_ir = ^ir_q[RS2_LSB-1:0];

  assign ctrl_bus.OPCODE = opc;

  always_comb begin
    op_wr = 1'b0;
    unique case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_SHL, OP_SHR: op_wr = 1'b1;
      default:                        op_wr = 1'b0;
    endcase
  end

`ifdef CONTROL_SEQ_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  logic op_known;

  assign op_known = op_wr | (opc == OP_NOP) | (opc == OP_HALT);
  assign illegal  = illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef CONTROL_SEQ_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_data;
          pc_d    = pc_q + WORD_SIZE'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opc == OP_HALT) state_d = S_HALT;
`ifdef CONTROL_SEQ_ILLEGAL_TRAP_EN
        else if (!op_known) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
`endif
        else state_d = S_EXEC;
      end
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign instr_req  = (state_q == S_FETCH);
  assign instr_addr = pc_q;
  assign alu_en     = (state_q == S_EXEC);
  assign reg_we     = (state_q == S_WB) && op_wr;
  assign halted     = (state_q == S_HALT);
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer plus a RESET_PC wrap instance.
module tb_control_sequencer;

  localparam logic [4:0] O_NOP  = 5'h00;
  localparam logic [4:0] O_ADD  = 5'h01;
  localparam logic [4:0] O_SUB  = 5'h02;
  localparam logic [4:0] O_AND  = 5'h03;
  localparam logic [4:0] O_OR   = 5'h04;
  localparam logic [4:0] O_XOR  = 5'h05;
  localparam logic [4:0] O_NOT  = 5'h06;
  localparam logic [4:0] O_HALT = 5'h1F;
  localparam logic [4:0] O_UND  = 5'h10;

  typedef struct packed {
    logic [4:0] op;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } alu_exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, instr_valid;
  logic [18:0] instr_data;
  logic        instr_req, alu_en, reg_we, busy, halted, illegal;
  logic [18:0] instr_addr;
  logic [3:0]  rs1_addr, rs2_addr, rd_addr;

  logic        start_w, valid_w;
  logic [18:0] data_w, addr_w;
  logic        req_w, alu_en_w, reg_we_w, busy_w, halted_w, illegal_w;
  logic [3:0]  rs1_w, rs2_w, rd_w;

  alu_exp_t    alu_q[$];
  logic [3:0]  wb_q[$];
  logic [18:0] mem [0:15];
  int          wait_left;
  bit          mem_auto;
  int          vectors, miscompares;
  int          alu_seen, wb_seen;

  always #5 clk = ~clk;

  control_bus_if #(.OPCODE_W(5)) bus ();
  control_bus_if #(.OPCODE_W(5)) bus_w ();

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .ctrl_bus(bus),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .alu_en(alu_en), .reg_we(reg_we), .busy(busy),
    .halted(halted), .illegal(illegal)
  );

  control_sequencer #(.RESET_PC(19'h7FFFF)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w),
    .instr_req(req_w), .instr_addr(addr_w),
    .instr_valid(valid_w), .instr_data(data_w),
    .ctrl_bus(bus_w),
    .rs1_addr(rs1_w), .rs2_addr(rs2_w), .rd_addr(rd_w),
    .alu_en(alu_en_w), .reg_we(reg_we_w), .busy(busy_w),
    .halted(halted_w), .illegal(illegal_w)
  );

  function automatic logic [18:0] mk(input logic [4:0] op,
    input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2, 2'b00};
  endfunction

  function automatic void expect_instr(input logic [18:0] d);
    logic [4:0] op;
    bit known;
    op = d[18:14];
    known = (op <= 5'h08) || (op == O_HALT);
    if (op == O_HALT) return;
`ifdef CONTROL_SEQ_ILLEGAL_TRAP_EN
    if (!known) return;
`endif
    alu_q.push_back({op, d[9:6], d[5:2]});
    if (known && op != O_NOP) wb_q.push_back(d[13:10]);
  endfunction

  task automatic cyc();
    alu_exp_t e;
    logic [3:0] rd;
    @(negedge clk);
    if (alu_en) begin
      alu_seen++;
      vectors++;
      if (alu_q.size() == 0) begin
        miscompares++;
        $display("FAIL alu_unexpected: got op=%h want none", bus.OPCODE);
      end else begin
        e = alu_q.pop_front();
        if ({bus.OPCODE, rs1_addr, rs2_addr} !== e) begin
          miscompares++;
          $display("FAIL alu_fields: got %h/%h/%h want %h/%h/%h",
            bus.OPCODE, rs1_addr, rs2_addr, e.op, e.rs1, e.rs2);
        end
      end
    end
    if (reg_we) begin
      wb_seen++;
      vectors++;
      if (wb_q.size() == 0) begin
        miscompares++;
        $display("FAIL wb_unexpected: got rd=%h want none", rd_addr);
      end else begin
        rd = wb_q.pop_front();
        if (rd_addr !== rd) begin
          miscompares++;
          $display("FAIL wb_rd: got %h want %h", rd_addr, rd);
        end
      end
    end
    if (mem_auto) begin
      if (instr_req && wait_left == 0) begin
        instr_valid = 1'b1;
        instr_data  = mem[instr_addr[3:0]];
        expect_instr(instr_data);
      end else begin
        instr_valid = 1'b0;
        if (instr_req && wait_left > 0) wait_left--;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    start_w = 1'b0;
    valid_w = 1'b0;
    data_w = '0;
    instr_valid = 1'b0;
    instr_data = '0;
    mem_auto = 1'b1;
    wait_left = 0;
    alu_q.delete();
    wb_q.delete();
    for (int i = 0; i < 16; i++) mem[i] = mk(O_HALT, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if ({instr_req, alu_en, reg_we, busy, halted, illegal} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b want 000000",
        {instr_req, alu_en, reg_we, busy, halted, illegal});
    end
    vectors++;
    if (instr_addr !== 19'h0 || bus.OPCODE !== 5'h0) begin
      miscompares++;
      $display("FAIL reset_pc_op: got pc=%h op=%h want 0/0",
        instr_addr, bus.OPCODE);
    end
    vectors++;
    if (addr_w !== 19'h7FFFF) begin
      miscompares++;
      $display("FAIL reset_pc_preset: got %h want 7ffff", addr_w);
    end
  endtask

  task automatic test_and();
    do_reset();
    mem[0] = mk(O_AND, 3, 1, 2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    vectors++;
    if (instr_req !== 1'b1 || instr_addr !== 19'd0) begin
      miscompares++;
      $display("FAIL and_fetch: got req=%b pc=%h want 1/0",
        instr_req, instr_addr);
    end
    cyc();
    vectors++;
    if (bus.OPCODE !== O_AND || rs1_addr !== 4'd1 || rs2_addr !== 4'd2) begin
      miscompares++;
      $display("FAIL and_decode: got %h/%h/%h want 03/1/2",
        bus.OPCODE, rs1_addr, rs2_addr);
    end
    cyc();
    vectors++;
    if (alu_en !== 1'b1 || reg_we !== 1'b0) begin
      miscompares++;
      $display("FAIL and_exec: got alu=%b we=%b want 1/0", alu_en, reg_we);
    end
    cyc();
    vectors++;
    if (reg_we !== 1'b1 || rd_addr !== 4'd3 || alu_en !== 1'b0) begin
      miscompares++;
      $display("FAIL and_wb: got we=%b rd=%h alu=%b want 1/3/0",
        reg_we, rd_addr, alu_en);
    end
    cyc();
    vectors++;
    if (instr_req !== 1'b1 || instr_addr !== 19'd1) begin
      miscompares++;
      $display("FAIL and_next: got req=%b pc=%h want 1/1",
        instr_req, instr_addr);
    end
    repeat (2) cyc();
    vectors++;
    if (halted !== 1'b1 || busy !== 1'b0 || alu_q.size() != 0) begin
      miscompares++;
      $display("FAIL and_halt: got halted=%b busy=%b pend=%0d want 1/0/0",
        halted, busy, alu_q.size());
    end
  endtask

  task automatic test_stall();
    bit bad;
    int wb0;
    do_reset();
    mem[0] = mk(O_OR, 5, 6, 7);
    wait_left = 5;
    wb0 = wb_seen;
    bad = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      start = 1'b0;
      if (instr_req !== 1'b1 || instr_addr !== 19'd0 ||
          alu_en !== 1'b0 || reg_we !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL stall_hold: got req/pc/strobes changing want held");
    end
    cyc();
    cyc();
    vectors++;
    if (instr_addr !== 19'd1 || bus.OPCODE !== O_OR) begin
      miscompares++;
      $display("FAIL stall_accept: got pc=%h op=%h want 1/04",
        instr_addr, bus.OPCODE);
    end
    for (int i = 0; i < 20 && !halted; i++) cyc();
    vectors++;
    if (halted !== 1'b1 || wb_seen - wb0 != 1) begin
      miscompares++;
      $display("FAIL stall_done: got halted=%b wb=%0d want 1/1",
        halted, wb_seen - wb0);
    end
  endtask

  task automatic test_sequence();
    bit req_seen;
    int wb0;
    do_reset();
    mem[0] = mk(O_XOR, 1, 2, 3);
    mem[1] = mk(O_NOT, 4, 5, 6);
    mem[2] = mk(O_HALT, 0, 0, 0);
    wb0 = wb_seen;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 30 && !halted; i++) cyc();
    vectors++;
    if (wb_seen - wb0 != 2) begin
      miscompares++;
      $display("FAIL seq_wb_count: got %0d want 2", wb_seen - wb0);
    end
    vectors++;
    if (halted !== 1'b1 || busy !== 1'b0 || instr_addr !== 19'd3) begin
      miscompares++;
      $display("FAIL seq_halt: got halted=%b busy=%b pc=%h want 1/0/3",
        halted, busy, instr_addr);
    end
    req_seen = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (instr_req !== 1'b0 || halted !== 1'b1) req_seen = 1'b1;
    end
    start = 1'b0;
    vectors++;
    if (req_seen) begin
      miscompares++;
      $display("FAIL seq_start_ignored: got req after halt want none");
    end
  endtask

  task automatic test_reset_mid_fetch();
    bit moved;
    do_reset();
    mem[0] = mk(O_ADD, 1, 2, 3);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_left = 1000;
    repeat (4) cyc();
    vectors++;
    if (instr_req !== 1'b1 || instr_addr !== 19'd1) begin
      miscompares++;
      $display("FAIL rmf_stalled: got req=%b pc=%h want 1/1",
        instr_req, instr_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (instr_req !== 1'b0 || instr_addr !== 19'd0) begin
      miscompares++;
      $display("FAIL rmf_async: got req=%b pc=%h want 0/0",
        instr_req, instr_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_auto = 1'b0;
    wait_left = 0;
    instr_valid = 1'b1;
    instr_data = mk(O_ADD, 7, 7, 7);
    moved = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (instr_req !== 1'b0 || busy !== 1'b0 ||
          bus.OPCODE !== 5'h0 || instr_addr !== 19'd0) moved = 1'b1;
    end
    vectors++;
    if (moved) begin
      miscompares++;
      $display("FAIL rmf_late_valid: got state change want idle");
    end
    instr_valid = 1'b0;
    mem_auto = 1'b1;
  endtask

  task automatic test_undefined();
    bit saw5, und_alu;
    int wb0;
    do_reset();
    mem[0] = mk(O_ADD, 1, 2, 3);
    mem[1] = mk(O_SUB, 2, 3, 4);
    mem[2] = mk(O_NOP, 0, 0, 0);
    mem[3] = mk(O_AND, 4, 5, 6);
    mem[4] = mk(O_UND, 9, 10, 11);
    mem[5] = mk(O_HALT, 0, 0, 0);
    wb0 = wb_seen;
    saw5 = 1'b0;
    und_alu = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 40 && !halted; i++) begin
      cyc();
      if (instr_req && instr_addr == 19'd5) saw5 = 1'b1;
      if (alu_en && bus.OPCODE == O_UND) und_alu = 1'b1;
    end
    vectors++;
    if (halted !== 1'b1 || wb_seen - wb0 != 3) begin
      miscompares++;
      $display("FAIL und_halt: got halted=%b wb=%0d want 1/3",
        halted, wb_seen - wb0);
    end
`ifdef CONTROL_SEQ_ILLEGAL_TRAP_EN
    vectors++;
    if (illegal !== 1'b1 || und_alu || saw5) begin
      miscompares++;
      $display("FAIL und_trap: got ill=%b alu=%b pc5=%b want 1/0/0",
        illegal, und_alu, saw5);
    end
`else
    vectors++;
    if (illegal !== 1'b0 || !und_alu || !saw5) begin
      miscompares++;
      $display("FAIL und_nop: got ill=%b alu=%b pc5=%b want 0/1/1",
        illegal, und_alu, saw5);
    end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    vectors++;
    if (req_w !== 1'b1 || addr_w !== 19'h7FFFF) begin
      miscompares++;
      $display("FAIL wrap_fetch: got req=%b pc=%h want 1/7ffff",
        req_w, addr_w);
    end
    valid_w = 1'b1;
    data_w = mk(O_NOP, 0, 0, 0);
    @(negedge clk);
    valid_w = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (req_w !== 1'b1 || addr_w !== 19'h0) begin
      miscompares++;
      $display("FAIL wrap_pc: got req=%b pc=%h want 1/0", req_w, addr_w);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    alu_seen = 0;
    wb_seen = 0;
    rst_n = 1'b0;
    start = 1'b0;
    start_w = 1'b0;
    valid_w = 1'b0;
    data_w = '0;
    instr_valid = 1'b0;
    instr_data = '0;
    mem_auto = 1'b1;
    wait_left = 0;
    test_reset();
    test_and();
    test_stall();
    test_sequence();
    test_reset_mid_fetch();
    test_undefined();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle fetch/decode/execute/writeback sequencer. It is the driving end of control_bus_if: it generates OPCODE and the per-instruction strobes that the ALU and its logical sub-unit consume.
- It fetches 19-bit instructions from instruction memory over a req/valid handshake and owns the program counter.
- It decodes instruction fields, sequences the ALU and register-file write, and stops on HALT.

Parameters:
- WORD_SIZE, 19, instruction and data width (matches constants::WORD_SIZE)
- OPCODE_W, 5, opcode field width, instr[18:14]
- REG_ADDR_W, 4, register address width: rd=instr[13:10], rs1=instr[9:6], rs2=instr[5:2]
- RESET_PC, 0, program counter value after reset

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin fetching from current PC when in IDLE
- instr_req  output  1  fetch request, held until accepted
- instr_addr  output  WORD_SIZE  fetch address (= PC)
- instr_valid  input  1  instr_data valid; accepted when instr_req & instr_valid
- instr_data  input  WORD_SIZE  fetched instruction
- ctrl_bus  interface  -  control_bus_if, control-unit modport; drives OPCODE
- rs1_addr  output  REG_ADDR_W  register-file read address 1
- rs2_addr  output  REG_ADDR_W  register-file read address 2
- rd_addr  output  REG_ADDR_W  register-file write address
- alu_en  output  1  ALU result valid to sample this cycle
- reg_we  output  1  register-file write enable, one cycle
- busy  output  1  state != IDLE and state != HALTED
- halted  output  1  sequencer stopped by HALT
- illegal  output  1  sticky illegal-opcode flag (feature only; tied 0 otherwise)

Behaviour:
- Reset (asynchronous, any state):
  - PC=RESET_PC; state=IDLE; instruction register=0.
  - OPCODE=NOP-equivalent 0; all strobes, busy, halted and illegal =0.
- States and transitions:
  - IDLE: instr_req=0. If start=1, go to FETCH next cycle.
  - FETCH: instr_req=1, instr_addr=PC. Stall indefinitely while instr_valid=0. On accept, latch instr_data into IR, PC<=PC+1, go to DECODE. instr_valid while instr_req=0 is ignored.
  - DECODE: IR fields are registered onto OPCODE, rs1_addr, rs2_addr and rd_addr, which then hold stable until the next DECODE. Opcode HALT goes to HALTED. Any other opcode goes to EXECUTE.
  - EXECUTE: alu_en=1 for exactly one cycle, then WRITEBACK.
  - WRITEBACK: reg_we=1 for exactly one cycle for AND/OR/XOR/NOT and other ALU ops. No write for NOP. Then FETCH (free-running; start not rechecked).
  - HALTED: halted=1, no requests. Left only by reset. start is ignored.
- Timing and decode rules:
  - Latency per instruction = 1 (fetch, zero-wait memory) + 3 = 4 cycles.
  - NOT uses rs1 only; rs2_addr is still driven from the field and must be ignored by the datapath.
  - PC wraps from 2^WORD_SIZE-1 to 0 without a flag.
  - Undefined opcodes without the optional feature are executed as NOP: pass through EXECUTE and WRITEBACK with alu_en=1 and reg_we=0.
  - start asserted while busy is ignored.
- Reset mid-fetch: instr_req drops asynchronously. A response arriving after reset release is ignored until the next FETCH.

Optional Feature:
- Macro: CONTROL_SEQ_ILLEGAL_TRAP_EN.
- Defined: an opcode not in the opcodes package sets illegal=1 (sticky until reset) and goes DECODE->HALTED. No alu_en and no reg_we are issued.
- Undefined: illegal is tied 0 and undefined opcodes run as NOP as described above.

Test Plan:
- Reset then start=1, memory returns AND r3,r1,r2 (rd=3, rs1=1, rs2=2) with zero wait:
  - instr_addr=0; OPCODE=AND with rs1_addr=1, rs2_addr=2 in cycle 2.
  - alu_en in cycle 3; reg_we with rd_addr=3 in cycle 4.
  - Next fetch at instr_addr=1.
- Fetch with instr_valid delayed 5 cycles: instr_req and instr_addr held constant for 5 cycles, no strobes fire, PC advances only after accept.
- Sequence XOR, NOT, HALT at PC 0..2:
  - Exactly two reg_we pulses.
  - halted=1 after the third decode, busy=0, and no further instr_req even with start=1.
- rst_n asserted while FETCH is stalled:
  - instr_req=0 immediately, PC=0.
  - A late instr_valid=1 after release, with start=0, causes no state change.
- Undefined opcode at PC=4:
  - Feature off: alu_en=1, reg_we=0, fetch continues at PC 5.
  - Feature on: illegal=1, halted=1, no alu_en.
- PC preset to 2^19-1 via RESET_PC override: after one fetch, instr_addr wraps to 0.
